// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the master-port FSM state type.
// Define AHB3LITE_IC_DECERR_EN to enable the two-cycle decode-error response states.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT_GRANT
`ifdef AHB3LITE_IC_DECERR_EN
        ,
        ST_ERR1,
        ST_ERR2
`endif
    } mport_state_e;

endpackage

// File: rtl/ahb3lite_interconnect_address_decoder.sv
// Combinational HADDR decoder: one-hot region hit (lowest index wins) and a miss flag.
// A slave region with an all-zero mask never matches.
module ahb3lite_interconnect_address_decoder
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int SLAVES     = 8
) (
    input  logic [HADDR_SIZE-1:0]             haddr_i,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0] base_i,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0] mask_i,
    output logic [SLAVES-1:0]                 hit_o,
    output logic                              miss_o
);

    always_comb begin
        hit_o  = '0;
        miss_o = 1'b1;
        for (int unsigned s = 0; s < SLAVES; s++) begin
            if (miss_o && (|mask_i[s]) && (((haddr_i ^ base_i[s]) & mask_i[s]) == '0)) begin
                hit_o[s] = 1'b1;
                miss_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-side port of the AHB3-Lite switch: decodes, requests slave ports, buffers ungranted transfers.
// Define AHB3LITE_IC_DECERR_EN to answer unmapped addresses with a two-cycle ERROR response.
module ahb3lite_interconnect_master_port
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3,
    parameter int SLAVES     = 8,
    parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLAVE_ADDR_BASE = '0,
    parameter logic [SLAVES-1:0][HADDR_SIZE-1:0] SLAVE_ADDR_MASK = '0,
    localparam int MASTER_BITS = $clog2(MASTERS),
    localparam int SLAVE_BITS  = $clog2(SLAVES)
) (
    input  logic                              HRESETn,
    input  logic                              HCLK,
    input  logic [MASTER_BITS-1:0]            mst_priority,
    input  logic                              mst_HSEL,
    input  logic [HADDR_SIZE-1:0]             mst_HADDR,
    input  logic [HDATA_SIZE-1:0]             mst_HWDATA,
    output logic [HDATA_SIZE-1:0]             mst_HRDATA,
    input  logic                              mst_HWRITE,
    input  logic [2:0]                        mst_HSIZE,
    input  logic [2:0]                        mst_HBURST,
    input  logic [3:0]                        mst_HPROT,
    input  logic [1:0]                        mst_HTRANS,
    input  logic                              mst_HMASTLOCK,
    input  logic                              mst_HREADY,
    output logic                              mst_HREADYOUT,
    output logic                              mst_HRESP,
    output logic [MASTER_BITS-1:0]            slvpriority,
    output logic [SLAVES-1:0]                 slvHSEL,
    output logic [HADDR_SIZE-1:0]             slvHADDR,
    output logic [HDATA_SIZE-1:0]             slvHWDATA,
    output logic                              slvHWRITE,
    output logic [2:0]                        slvHSIZE,
    output logic [2:0]                        slvHBURST,
    output logic [3:0]                        slvHPROT,
    output logic [1:0]                        slvHTRANS,
    output logic                              slvHMASTLOCK,
    output logic                              slvHREADYOUT,
    input  logic [SLAVES-1:0][HDATA_SIZE-1:0] slvHRDATA,
    input  logic [SLAVES-1:0]                 slvHREADY,
    input  logic [SLAVES-1:0]                 slvHRESP,
    input  logic [SLAVES-1:0]                 granted,
    output logic [SLAVES-1:0]                 can_switch
);

    mport_state_e          state_q, state_d;
    logic [SLAVE_BITS-1:0] data_slave_q, data_slave_d;
    logic [SLAVE_BITS-1:0] buf_slave_q, buf_slave_d;
    logic [HADDR_SIZE-1:0] buf_haddr_q, buf_haddr_d;
    logic                  buf_hwrite_q, buf_hwrite_d;
    logic [2:0]            buf_hsize_q, buf_hsize_d;
    logic [2:0]            buf_hburst_q, buf_hburst_d;
    logic [3:0]            buf_hprot_q, buf_hprot_d;
    logic                  buf_hlock_q, buf_hlock_d;

    logic [SLAVES-1:0]     hit;
    logic                  miss;
    logic [SLAVE_BITS-1:0] dec_idx;
    logic                  accept;
    logic                  pass;
    logic                  evaluate;
    logic                  wait_st;

    ahb3lite_interconnect_address_decoder #(
        .HADDR_SIZE (HADDR_SIZE),
        .SLAVES     (SLAVES)
    ) u_decoder (
        .haddr_i (mst_HADDR),
        .base_i  (SLAVE_ADDR_BASE),
        .mask_i  (SLAVE_ADDR_MASK),
        .hit_o   (hit),
        .miss_o  (miss)
    );

    always_comb begin
        dec_idx = '0;
        for (int unsigned s = 0; s < SLAVES; s++) begin
            if (hit[s]) dec_idx = SLAVE_BITS'(s);
        end
    end

    assign accept  = mst_HSEL & mst_HREADY & mst_HTRANS[1];
    assign pass    = |(hit & granted & slvHREADY);
    assign wait_st = (state_q == ST_WAIT_GRANT);

    always_comb begin
        state_d      = state_q;
        data_slave_d = data_slave_q;
        buf_slave_d  = buf_slave_q;
        buf_haddr_d  = buf_haddr_q;
        buf_hwrite_d = buf_hwrite_q;
        buf_hsize_d  = buf_hsize_q;
        buf_hburst_d = buf_hburst_q;
        buf_hprot_d  = buf_hprot_q;
        buf_hlock_d  = buf_hlock_q;
        evaluate     = 1'b0;

        case (state_q)
            ST_IDLE: evaluate = 1'b1;
            ST_DATA: evaluate = slvHREADY[data_slave_q];
            ST_WAIT_GRANT: begin
                if (granted[buf_slave_q] && slvHREADY[buf_slave_q]) begin
                    state_d      = ST_DATA;
                    data_slave_d = buf_slave_q;
                end
            end
`ifdef AHB3LITE_IC_DECERR_EN
            ST_ERR1: state_d  = ST_ERR2;
            ST_ERR2: evaluate = 1'b1;
`endif
            default: evaluate = 1'b1;
        endcase

        if (evaluate) begin
            state_d = ST_IDLE;
            if (accept) begin
                if (miss) begin
`ifdef AHB3LITE_IC_DECERR_EN
                    state_d = ST_ERR1;
`endif
                end else if (pass) begin
                    state_d      = ST_DATA;
                    data_slave_d = dec_idx;
                end else begin
                    state_d      = ST_WAIT_GRANT;
                    buf_slave_d  = dec_idx;
                    buf_haddr_d  = mst_HADDR;
                    buf_hwrite_d = mst_HWRITE;
                    buf_hsize_d  = mst_HSIZE;
                    buf_hburst_d = mst_HBURST;
                    buf_hprot_d  = mst_HPROT;
                    buf_hlock_d  = mst_HMASTLOCK;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            data_slave_q <= '0;
            buf_slave_q  <= '0;
            buf_haddr_q  <= '0;
            buf_hwrite_q <= 1'b0;
            buf_hsize_q  <= '0;
            buf_hburst_q <= '0;
            buf_hprot_q  <= '0;
            buf_hlock_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_slave_q <= data_slave_d;
            buf_slave_q  <= buf_slave_d;
            buf_haddr_q  <= buf_haddr_d;
            buf_hwrite_q <= buf_hwrite_d;
            buf_hsize_q  <= buf_hsize_d;
            buf_hburst_q <= buf_hburst_d;
            buf_hprot_q  <= buf_hprot_d;
            buf_hlock_q  <= buf_hlock_d;
        end
    end

    // A replayed transfer is the first one the slave port sees, so it is always NONSEQ.
    assign slvHADDR     = wait_st ? buf_haddr_q  : mst_HADDR;
    assign slvHWRITE    = wait_st ? buf_hwrite_q : mst_HWRITE;
    assign slvHSIZE     = wait_st ? buf_hsize_q  : mst_HSIZE;
    assign slvHBURST    = wait_st ? buf_hburst_q : mst_HBURST;
    assign slvHPROT     = wait_st ? buf_hprot_q  : mst_HPROT;
    assign slvHTRANS    = wait_st ? HTRANS_NONSEQ : mst_HTRANS;
    assign slvHMASTLOCK = wait_st ? buf_hlock_q  : mst_HMASTLOCK;
    assign slvHWDATA    = mst_HWDATA;
    assign slvHREADYOUT = mst_HREADYOUT;
    assign slvpriority  = mst_priority;

    always_comb begin
        for (int unsigned s = 0; s < SLAVES; s++) begin
            slvHSEL[s] = wait_st ? (buf_slave_q == SLAVE_BITS'(s))
                                 : (hit[s] & mst_HSEL & (mst_HTRANS != HTRANS_IDLE));
            can_switch[s] = ~(slvHSEL[s] & (slvHMASTLOCK | (slvHTRANS == HTRANS_SEQ) |
                                            (slvHTRANS == HTRANS_BUSY)));
        end
    end

    always_comb begin
        mst_HREADYOUT = 1'b1;
        mst_HRESP     = HRESP_OKAY;
        mst_HRDATA    = '0;
        case (state_q)
            ST_DATA: begin
                mst_HREADYOUT = slvHREADY[data_slave_q];
                mst_HRESP     = slvHRESP[data_slave_q];
                mst_HRDATA    = slvHRDATA[data_slave_q];
            end
            ST_WAIT_GRANT: mst_HREADYOUT = 1'b0;
`ifdef AHB3LITE_IC_DECERR_EN
            ST_ERR1: begin
                mst_HREADYOUT = 1'b0;
                mst_HRESP     = HRESP_ERROR;
            end
            ST_ERR2: mst_HRESP = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Directed cycle-table bench for the AHB3-Lite switch master port, plus a reset-during-wait sequence.
// Expected decode-miss responses follow AHB3LITE_IC_DECERR_EN when it is defined.
module tb_ahb3lite_interconnect_master_port;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    localparam logic [7:0][31:0] BASE = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                         32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [7:0][31:0] MASK = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                         32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [1:0]       mst_priority;
    logic             mst_HSEL;
    logic [31:0]      mst_HADDR;
    logic [31:0]      mst_HWDATA;
    logic [31:0]      mst_HRDATA;
    logic             mst_HWRITE;
    logic [2:0]       mst_HSIZE;
    logic [2:0]       mst_HBURST;
    logic [3:0]       mst_HPROT;
    logic [1:0]       mst_HTRANS;
    logic             mst_HMASTLOCK;
    logic             mst_HREADY;
    logic             mst_HREADYOUT;
    logic             mst_HRESP;
    logic [1:0]       slvpriority;
    logic [7:0]       slvHSEL;
    logic [31:0]      slvHADDR;
    logic [31:0]      slvHWDATA;
    logic             slvHWRITE;
    logic [2:0]       slvHSIZE;
    logic [2:0]       slvHBURST;
    logic [3:0]       slvHPROT;
    logic [1:0]       slvHTRANS;
    logic             slvHMASTLOCK;
    logic             slvHREADYOUT;
    logic [7:0][31:0] slvHRDATA;
    logic [7:0]       slvHREADY;
    logic [7:0]       slvHRESP;
    logic [7:0]       granted;
    logic [7:0]       can_switch;

    int n_pass = 0;
    int n_total = 0;

    always #5 HCLK = ~HCLK;

    assign mst_HREADY = mst_HREADYOUT;

    ahb3lite_interconnect_master_port #(
        .HADDR_SIZE      (32),
        .HDATA_SIZE      (32),
        .MASTERS         (3),
        .SLAVES          (8),
        .SLAVE_ADDR_BASE (BASE),
        .SLAVE_ADDR_MASK (MASK)
    ) dut (
        .HRESETn       (HRESETn),
        .HCLK          (HCLK),
        .mst_priority  (mst_priority),
        .mst_HSEL      (mst_HSEL),
        .mst_HADDR     (mst_HADDR),
        .mst_HWDATA    (mst_HWDATA),
        .mst_HRDATA    (mst_HRDATA),
        .mst_HWRITE    (mst_HWRITE),
        .mst_HSIZE     (mst_HSIZE),
        .mst_HBURST    (mst_HBURST),
        .mst_HPROT     (mst_HPROT),
        .mst_HTRANS    (mst_HTRANS),
        .mst_HMASTLOCK (mst_HMASTLOCK),
        .mst_HREADY    (mst_HREADY),
        .mst_HREADYOUT (mst_HREADYOUT),
        .mst_HRESP     (mst_HRESP),
        .slvpriority   (slvpriority),
        .slvHSEL       (slvHSEL),
        .slvHADDR      (slvHADDR),
        .slvHWDATA     (slvHWDATA),
        .slvHWRITE     (slvHWRITE),
        .slvHSIZE      (slvHSIZE),
        .slvHBURST     (slvHBURST),
        .slvHPROT      (slvHPROT),
        .slvHTRANS     (slvHTRANS),
        .slvHMASTLOCK  (slvHMASTLOCK),
        .slvHREADYOUT  (slvHREADYOUT),
        .slvHRDATA     (slvHRDATA),
        .slvHREADY     (slvHREADY),
        .slvHRESP      (slvHRESP),
        .granted       (granted),
        .can_switch    (can_switch)
    );

    typedef struct {
        logic        hsel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic        lock;
        logic [7:0]  gnt;
        logic [7:0]  srdy;
        logic [7:0]  sresp;
        logic [7:0]  e_sel;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic [31:0] e_addr;
        logic [1:0]  e_trans;
        logic        e_write;
        logic [7:0]  e_cs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic hsel, logic [1:0] trans, logic [31:0] addr, logic write,
                                logic lock, logic [7:0] gnt, logic [7:0] srdy, logic [7:0] sresp,
                                logic [7:0] e_sel, logic e_rdy, logic e_resp, logic [31:0] e_rdata,
                                logic [31:0] e_addr, logic [1:0] e_trans, logic e_write,
                                logic [7:0] e_cs);
        vec_t v;
        v.hsel = hsel;   v.trans = trans;   v.addr = addr;     v.write = write;
        v.lock = lock;   v.gnt = gnt;       v.srdy = srdy;     v.sresp = sresp;
        v.e_sel = e_sel; v.e_rdy = e_rdy;   v.e_resp = e_resp; v.e_rdata = e_rdata;
        v.e_addr = e_addr; v.e_trans = e_trans; v.e_write = e_write; v.e_cs = e_cs;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive_idle(input logic [7:0] gnt);
        mst_HSEL      = 1'b0;
        mst_HTRANS    = T_IDLE;
        mst_HADDR     = 32'h0;
        mst_HWRITE    = 1'b0;
        mst_HMASTLOCK = 1'b0;
        mst_HBURST    = 3'b000;
        granted       = gnt;
        slvHREADY     = 8'hFF;
        slvHRESP      = 8'h00;
    endtask

    initial begin
        slvHRDATA    = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFF, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        mst_priority = 2'd2;
        mst_HWDATA   = 32'h1234_5678;
        mst_HSIZE    = 3'b010;
        mst_HPROT    = 4'b0011;
        drive_idle(8'h00);
        HRESETn = 1'b0;

        // hsel trans addr wr lk gnt srdy sresp | sel rdy resp rdata addr trans wr cs
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h0, 32'h0, T_IDLE, 0, 8'hFF));
        // pass-through read to granted slave 0
        vecs.push_back(mk(1, T_NS, 32'h10, 0, 0, 8'h01, 8'hFF, 8'h00, 8'h01, 1, 0, 32'h0, 32'h10, T_NS, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h01, 8'hFF, 8'h00, 8'h00, 1, 0, 32'hDEAD_BEEF, 32'h0, T_IDLE, 0, 8'hFF));
        // write to slave 1, grant withheld for three wait cycles
        vecs.push_back(mk(1, T_NS, 32'h1000_0040, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h02, 1, 0, 32'h0, 32'h1000_0040, T_NS, 1, 8'hFF));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h02, 0, 0, 32'h0, 32'h1000_0040, T_NS, 1, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h02, 8'hFF, 8'h00, 8'h02, 0, 0, 32'h0, 32'h1000_0040, T_NS, 1, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h02, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h1111_1111, 32'h0, T_IDLE, 0, 8'hFF));
        // SEQ to ungranted slave 2 is replayed as NONSEQ
        vecs.push_back(mk(1, T_SEQ, 32'h2000_0004, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h04, 1, 0, 32'h0, 32'h2000_0004, T_SEQ, 0, 8'hFB));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h04, 0, 0, 32'h0, 32'h2000_0004, T_NS, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h04, 8'hFF, 8'h00, 8'h04, 0, 0, 32'h0, 32'h2000_0004, T_NS, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h04, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h2222_2222, 32'h0, T_IDLE, 0, 8'hFF));
        // unmapped address
        vecs.push_back(mk(1, T_NS, 32'h9000_0000, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h0, 32'h9000_0000, T_NS, 0, 8'hFF));
`ifdef AHB3LITE_IC_DECERR_EN
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 1, 32'h0, 32'h0, T_IDLE, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 1, 32'h0, 32'h0, T_IDLE, 0, 8'hFF));
`else
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h0, 32'h0, T_IDLE, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h0, 32'h0, T_IDLE, 0, 8'hFF));
`endif
        // locked INCR4 to slave 2: no switching while the burst runs
        vecs.push_back(mk(1, T_NS, 32'h2000_0000, 0, 1, 8'h04, 8'hFF, 8'h00, 8'h04, 1, 0, 32'h0, 32'h2000_0000, T_NS, 0, 8'hFB));
        vecs.push_back(mk(1, T_SEQ, 32'h2000_0004, 0, 1, 8'h04, 8'hFF, 8'h00, 8'h04, 1, 0, 32'h2222_2222, 32'h2000_0004, T_SEQ, 0, 8'hFB));
        vecs.push_back(mk(1, T_SEQ, 32'h2000_0008, 0, 1, 8'h04, 8'hFF, 8'h00, 8'h04, 1, 0, 32'h2222_2222, 32'h2000_0008, T_SEQ, 0, 8'hFB));
        vecs.push_back(mk(1, T_SEQ, 32'h2000_000C, 0, 1, 8'h04, 8'hFF, 8'h00, 8'h04, 1, 0, 32'h2222_2222, 32'h2000_000C, T_SEQ, 0, 8'hFB));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h04, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h2222_2222, 32'h0, T_IDLE, 0, 8'hFF));
        // slave ERROR (two cycles) forwarded unchanged
        vecs.push_back(mk(1, T_NS, 32'h20, 0, 0, 8'h01, 8'hFF, 8'h00, 8'h01, 1, 0, 32'h0, 32'h20, T_NS, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h01, 8'hFE, 8'h01, 8'h00, 0, 1, 32'hDEAD_BEEF, 32'h0, T_IDLE, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h01, 8'hFF, 8'h01, 8'h00, 1, 1, 32'hDEAD_BEEF, 32'h0, T_IDLE, 0, 8'hFF));
        vecs.push_back(mk(0, T_IDLE, 32'h0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 1, 0, 32'h0, 32'h0, T_IDLE, 0, 8'hFF));

        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge HCLK);
            mst_HSEL      = vecs[i].hsel;
            mst_HTRANS    = vecs[i].trans;
            mst_HADDR     = vecs[i].addr;
            mst_HWRITE    = vecs[i].write;
            mst_HMASTLOCK = vecs[i].lock;
            mst_HBURST    = vecs[i].lock ? 3'b011 : 3'b000;
            granted       = vecs[i].gnt;
            slvHREADY     = vecs[i].srdy;
            slvHRESP      = vecs[i].sresp;
            #1;
            chk($sformatf("v%0d.hsel", i),   32'(slvHSEL),       32'(vecs[i].e_sel));
            chk($sformatf("v%0d.ready", i),  32'(mst_HREADYOUT), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d.resp", i),   32'(mst_HRESP),     32'(vecs[i].e_resp));
            chk($sformatf("v%0d.rdata", i),  mst_HRDATA,         vecs[i].e_rdata);
            chk($sformatf("v%0d.haddr", i),  slvHADDR,           vecs[i].e_addr);
            chk($sformatf("v%0d.htrans", i), 32'(slvHTRANS),     32'(vecs[i].e_trans));
            chk($sformatf("v%0d.hwrite", i), 32'(slvHWRITE),     32'(vecs[i].e_write));
            chk($sformatf("v%0d.cansw", i),  32'(can_switch),    32'(vecs[i].e_cs));
        end

        // reset asserted while a write waits for grant
        @(negedge HCLK);
        drive_idle(8'h00);
        mst_HSEL   = 1'b1;
        mst_HTRANS = T_NS;
        mst_HADDR  = 32'h1000_0080;
        mst_HWRITE = 1'b1;
        #1;
        chk("rst.hwdata", slvHWDATA, 32'h1234_5678);
        chk("rst.prio", 32'(slvpriority), 32'd2);
        chk("rst.slvready", 32'(slvHREADYOUT), 32'd1);
        @(negedge HCLK);
        drive_idle(8'h00);
        #1;
        chk("rst.wait_ready", 32'(mst_HREADYOUT), 32'd0);
        chk("rst.wait_sel", 32'(slvHSEL), 32'h02);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst.sel", 32'(slvHSEL), 32'h00);
        chk("rst.ready", 32'(mst_HREADYOUT), 32'd1);
        chk("rst.cansw", 32'(can_switch), 32'hFF);
        chk("rst.haddr", slvHADDR, 32'h0);
        @(negedge HCLK);
        granted = 8'h02;
        HRESETn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            #1;
            chk($sformatf("post%0d.sel", k), 32'(slvHSEL), 32'h00);
            chk($sformatf("post%0d.ready", k), 32'(mst_HREADYOUT), 32'd1);
            chk($sformatf("post%0d.rdata", k), mst_HRDATA, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb3lite_interconnect_master_port.md
Name: ahb3lite_interconnect_master_port

Overview:
- Master-side port of the AHB3-Lite multi-layer switch; one instance per AHB master.
- Acts as an AHB slave toward its master. Decodes HADDR to one of SLAVES slave ports and requests that port by asserting a per-slave HSEL.
- If the target slave port has not yet granted this master, the block buffers the address phase and inserts wait states.
- Routes the granted slave's response (HRDATA/HREADY/HRESP) back to the master.
- Generates an AHB ERROR response for unmapped addresses.

Parameters:
- HADDR_SIZE, 32, address bus width.
- HDATA_SIZE, 32, data bus width.
- MASTERS, 3, number of masters in switch; sizes priority field.
- SLAVES, 8, number of slave ports.
- MASTER_BITS, $clog2(MASTERS), priority width; localparam.
- SLAVE_BITS, $clog2(SLAVES), slave index width; localparam.
- SLAVE_ADDR_BASE, all zeros, [SLAVES][HADDR_SIZE] region base per slave.
- SLAVE_ADDR_MASK, all zeros, [SLAVES][HADDR_SIZE] compare mask per slave; all zeros disables that slave.

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  clock, rising edge
- mst_priority  in  MASTER_BITS  static priority of this master
- mst_HSEL  in  1  master-side HSEL
- mst_HADDR  in  HADDR_SIZE  address
- mst_HWDATA  in  HDATA_SIZE  write data
- mst_HRDATA  out  HDATA_SIZE  read data
- mst_HWRITE  in  1  write strobe
- mst_HSIZE  in  3  transfer size
- mst_HBURST  in  3  burst type
- mst_HPROT  in  4  protection
- mst_HTRANS  in  2  transfer type
- mst_HMASTLOCK  in  1  locked transfer
- mst_HREADY  in  1  bus HREADY from master side
- mst_HREADYOUT  out  1  ready to master
- mst_HRESP  out  1  response to master
- slvpriority  out  MASTER_BITS  equals mst_priority
- slvHSEL  out  SLAVES  one-hot request per slave port
- slvHADDR, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK  out  same widths as master-side  shared address-phase bus
- slvHWDATA  out  HDATA_SIZE  equals mst_HWDATA
- slvHREADYOUT  out  1  equals internal mst_HREADYOUT; feeds slave ports' HREADY
- slvHRDATA  in  [SLAVES][HDATA_SIZE]  read data per slave port
- slvHREADY  in  SLAVES  HREADYOUT of each slave port
- slvHRESP  in  SLAVES  HRESP of each slave port
- granted  in  SLAVES  this master's granted_master bit from each slave port
- can_switch  out  SLAVES  per slave: this master may be switched away

Behaviour:
- Decode: hit[s] = ((HADDR ^ BASE[s]) & MASK[s]) == 0 with MASK[s] != 0. Lowest index wins. No hit means decode error.
- Transfer accepted when mst_HSEL & mst_HREADY & HTRANS ∈ {NONSEQ, SEQ}. IDLE and BUSY produce a zero-wait OKAY.
- FSM states: IDLE, DATA, WAIT_GRANT, ERR1, ERR2.
- Transitions on an accepted transfer to slave s:
  - granted[s] & slvHREADY[s]: pass through combinationally, zero added latency; data_slave <= s; go to DATA.
  - Otherwise: capture the address phase into the buffer; go to WAIT_GRANT.
  - Decode miss: go to ERR1.
  - No transfer accepted: IDLE.
- DATA:
  - mst_HREADYOUT = slvHREADY[data_slave], mst_HRESP = slvHRESP[data_slave], mst_HRDATA = slvHRDATA[data_slave].
  - When the data phase completes, the next state is evaluated with the same rules.
- WAIT_GRANT:
  - Address-phase outputs driven from the buffer; slvHSEL[s] = 1; mst_HREADYOUT = 0; mst_HRESP = OKAY.
  - On granted[s] & slvHREADY[s]: data_slave <= s; go to DATA.
  - A buffered SEQ is presented as NONSEQ.
- ERR1: HREADYOUT = 0, HRESP = 1. Next state ERR2.
- ERR2: HREADYOUT = 1, HRESP = 1. Then re-evaluate as from IDLE; a new accepted transfer is legal in ERR2.
- Outside WAIT_GRANT, address-phase outputs are the master inputs directly. slvHSEL is the one-hot of hit, gated by mst_HSEL and HTRANS != IDLE.
- can_switch[s] = !(slvHSEL[s] & (slvHMASTLOCK | slvHTRANS ∈ {SEQ, BUSY})).
- Simultaneous events: grant arriving in the same cycle as the transfer is accepted gives pass-through with no buffering. Slave ERROR in DATA is forwarded unchanged.
- Reset values:
  - state IDLE, buffer cleared, data_slave 0.
  - mst_HREADYOUT 1, mst_HRESP 0, mst_HRDATA 0.
  - slvHSEL 0, can_switch all 1.
- Reset asserted mid-operation discards any buffered transfer immediately (asynchronous).

Optional Feature:
- Macro AHB3LITE_IC_DECERR_EN.
- Defined: a decode miss produces the two-cycle ERR1/ERR2 response described above.
- Undefined: a decode miss completes as zero-wait OKAY with HRDATA = 0; ERR1/ERR2 states are absent.

Decomposition:
- ahb3lite_pkg holds HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HBURST codes, and the FSM state enum.
- One sub-module: ahb3lite_interconnect_address_decoder (HADDR, BASE/MASK in; one-hot hit plus miss flag out; purely combinational).

Test Plan:
- SLAVE0 base 0x0000_0000 mask 0xF000_0000, granted[0] = 1. NONSEQ read at 0x0000_0010 -> slvHSEL = 0x01 in the same cycle; mst_HRDATA = slvHRDATA[0] = 0xDEAD_BEEF with zero added wait states.
- Write to slave 1 while granted[1] = 0 for 3 cycles, then 1 -> mst_HREADYOUT low 4 cycles; buffered HADDR held on slvHADDR; write completes with HWDATA 0x1234_5678.
- SEQ beat to a not-granted slave -> slvHTRANS shows NONSEQ when replayed.
- Access to 0x9000_0000 with no region mapped, DECERR_EN defined -> HREADYOUT/HRESP = 0/1 then 1/1. Macro undefined -> 1/0 in one cycle.
- Locked INCR4 to slave 2 -> can_switch[2] = 0 through all beats; returns to 1 on IDLE.
- Assert HRESETn low during WAIT_GRANT -> slvHSEL = 0, mst_HREADYOUT = 1 immediately; no transfer replayed after release.
